// File: rtl/hazard3_break_ctrl_pkg.sv
// Shared constants and state encoding for the trigger break consumer, so the
// trap/debug-entry sequencing and this block agree on causes and states.
package hazard3_break_ctrl_pkg;

  localparam int         DEF_W_ADDR     = 32;
  localparam logic [3:0] DEF_CAUSE_DBG  = 4'd2;  // dcsr.cause: trigger entry to D-mode
  localparam logic [3:0] DEF_CAUSE_MBRK = 4'd3;  // mcause: breakpoint exception

  typedef enum logic [1:0] {
    BRK_IDLE   = 2'd0,  // no break outstanding
    BRK_PEND   = 2'd1,  // trap request raised, waiting for trap_ack
    BRK_WAIT_D = 2'd2   // D-mode entry accepted, waiting for d_mode to assert
  } brk_state_e;

endpackage

// File: rtl/hazard3_break_ctrl.sv
// Consumer end of the trigger unit's break request: captures a break against
// the decode-stage instruction, holds off its issue, and raises a held trap
// request with cause and EPC. Suppresses an immediate re-fire on resume.
module hazard3_break_ctrl
  import hazard3_break_ctrl_pkg::*;
#(
  parameter int         W_ADDR     = DEF_W_ADDR,
  parameter logic [3:0] CAUSE_DBG  = DEF_CAUSE_DBG,
  parameter logic [3:0] CAUSE_MBRK = DEF_CAUSE_MBRK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              brk_req,
  input  logic              brk_d_mode,
  input  logic [W_ADDR-1:0] brk_pc,
  input  logic              instr_valid,
  input  logic              instr_stall,
  input  logic              flush,
  input  logic              d_mode,
  input  logic              trap_return,
  input  logic              trap_ack,
  output logic              suppress_issue,
  output logic              trap_req,
  output logic              trap_d_mode,
  output logic [3:0]        trap_cause,
  output logic [W_ADDR-1:0] trap_epc
);

  brk_state_e state;
  logic       skip_first;
  logic       d_mode_q;
  logic       capture;
  logic       issue;
  logic       skip_set;
  logic       skip_clr;

  // Capture decision and issue blocking; suppression covers the capture cycle
  // itself so the breaking instruction can never slip through decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which is what would otherwise infer a latch.
    capture        = 1'b0;
    suppress_issue = 1'b0;
    if (state == BRK_IDLE) begin
      capture = brk_req & instr_valid & ~d_mode & ~skip_first & ~flush;
    end
    suppress_issue = capture | (state != BRK_IDLE);
    issue          = instr_valid & ~instr_stall & ~suppress_issue;
    skip_set       = (d_mode_q & ~d_mode) | trap_return;
    skip_clr       = issue | flush;
  end

  // Break FSM with registered trap request and captured trap payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BRK_IDLE;
      trap_req    <= 1'b0;
      trap_d_mode <= 1'b0;
      trap_cause  <= 4'd0;
      trap_epc    <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register in this
      // block updates from pre-edge values regardless of statement order.
      unique case (state)
        BRK_IDLE: begin
          if (capture) begin
            state       <= BRK_PEND;
            trap_req    <= 1'b1;
            trap_d_mode <= brk_d_mode;
            trap_cause  <= brk_d_mode ? CAUSE_DBG : CAUSE_MBRK;
            trap_epc    <= brk_pc;
          end
        end
        BRK_PEND: begin
          // Ack wins over a same-cycle flush: our own trap causes that flush.
          if (trap_ack) begin
            trap_req <= 1'b0;
            state    <= trap_d_mode ? BRK_WAIT_D : BRK_IDLE;
          end else if (flush) begin
            trap_req <= 1'b0;
            state    <= BRK_IDLE;
          end
        end
        BRK_WAIT_D: begin
          if (d_mode) state <= BRK_IDLE;
        end
        default: begin
          state    <= BRK_IDLE;
          trap_req <= 1'b0;
        end
      endcase
    end
  end

  // Resume tracking: let the instruction at the resume PC issue once without
  // re-triggering. A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_mode_q   <= 1'b0;
      skip_first <= 1'b0;
    end else begin
      d_mode_q <= d_mode;
      if (skip_set)      skip_first <= 1'b1;
      else if (skip_clr) skip_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard3_break_ctrl.sv
// Directed scenarios followed by randomized traffic, every cycle checked
// against a transaction-level model of outstanding breaks.
module tb_hazard3_break_ctrl;

  localparam logic [3:0] C_DBG  = 4'd2;
  localparam logic [3:0] C_MBRK = 4'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        brk_req = 1'b0, brk_d_mode = 1'b0;
  logic [31:0] brk_pc = '0;
  logic        instr_valid = 1'b0, instr_stall = 1'b0, flush = 1'b0;
  logic        d_mode = 1'b0, trap_return = 1'b0, trap_ack = 1'b0;
  logic        suppress_issue, trap_req, trap_d_mode;
  logic [3:0]  trap_cause;
  logic [31:0] trap_epc;

  int total = 0;
  int bad   = 0;

  // Model: a queue holding the (at most one) break that is owed to the trap
  // logic, a flag for a debug entry that has been accepted but not yet seen,
  // and the one-shot resume exemption.
  typedef struct {
    logic [31:0] pc;
    logic        dm;
  } brk_rec_t;
  brk_rec_t outstanding[$];
  bit       owe_dentry;
  bit       skip_once;
  bit       last_d;

  hazard3_break_ctrl dut (
    .clk(clk), .rst_n(rst_n), .brk_req(brk_req), .brk_d_mode(brk_d_mode),
    .brk_pc(brk_pc), .instr_valid(instr_valid), .instr_stall(instr_stall),
    .flush(flush), .d_mode(d_mode), .trap_return(trap_return),
    .trap_ack(trap_ack), .suppress_issue(suppress_issue), .trap_req(trap_req),
    .trap_d_mode(trap_d_mode), .trap_cause(trap_cause), .trap_epc(trap_epc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    outstanding.delete();
    owe_dentry = 1'b0;
    skip_once  = 1'b0;
    last_d     = 1'b0;
  endtask

  // One clock: inputs were set by the caller just after the previous edge.
  task automatic step();
    bit       busy, fires, issued;
    brk_rec_t r;
    #2;
    busy  = (outstanding.size() != 0) || owe_dentry;
    fires = !busy && brk_req && instr_valid && !d_mode && !skip_once && !flush;
    check("suppress", {31'd0, suppress_issue}, {31'd0, busy || fires});
    issued = instr_valid && !instr_stall && !(busy || fires);
    if (fires) begin
      r.pc = brk_pc;
      r.dm = brk_d_mode;
      outstanding.push_back(r);
    end else if (outstanding.size() != 0) begin
      if (trap_ack) begin
        owe_dentry = outstanding[0].dm;
        outstanding.delete();
      end else if (flush) begin
        outstanding.delete();
      end
    end else if (owe_dentry && d_mode) begin
      owe_dentry = 1'b0;
    end
    if ((last_d && !d_mode) || trap_return) skip_once = 1'b1;
    else if (issued || flush)               skip_once = 1'b0;
    last_d = d_mode;
    @(posedge clk);
    #1;
    check("trap_req", {31'd0, trap_req}, {31'd0, outstanding.size() != 0});
    if (outstanding.size() != 0) begin
      check("epc", trap_epc, outstanding[0].pc);
      check("tdm", {31'd0, trap_d_mode}, {31'd0, outstanding[0].dm});
      check("cause", {28'd0, trap_cause}, {28'd0, outstanding[0].dm ? C_DBG : C_MBRK});
    end
  endtask

  task automatic idle_inputs();
    brk_req = 0; brk_d_mode = 0; instr_valid = 0; instr_stall = 0;
    flush = 0; trap_return = 0; trap_ack = 0;
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    check("rst_req", {31'd0, trap_req}, 32'd0);
    check("rst_supp", {31'd0, suppress_issue}, 32'd0);
    check("rst_epc", trap_epc, 32'd0);
    check("rst_cause", {28'd0, trap_cause}, 32'd0);
    check("rst_tdm", {31'd0, trap_d_mode}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: M-mode break at 0x100, ack after three held cycles
    brk_pc = 32'h100; brk_req = 1; instr_valid = 1;
    step();
    check("t1_req", {31'd0, trap_req}, 32'd1);
    check("t1_epc", trap_epc, 32'h100);
    check("t1_cause", {28'd0, trap_cause}, 32'd3);
    brk_req = 0;
    repeat (3) step();
    check("t1_held", {31'd0, trap_req}, 32'd1);
    trap_ack = 1;
    step();
    trap_ack = 0;
    check("t1_ack", {31'd0, trap_req}, 32'd0);
    #1 check("t1_idle", {31'd0, suppress_issue}, 32'd0);

    // 2: D-mode break at 0x2000, suppression held until d_mode
    brk_pc = 32'h2000; brk_d_mode = 1; brk_req = 1;
    step();
    check("t2_cause", {28'd0, trap_cause}, 32'd2);
    check("t2_tdm", {31'd0, trap_d_mode}, 32'd1);
    brk_req = 0; trap_ack = 1;
    step();
    trap_ack = 0;
    repeat (2) step();
    check("t2_wait", {31'd0, suppress_issue}, 32'd1);
    d_mode = 1;
    step();
    #1 check("t2_rel", {31'd0, suppress_issue}, 32'd0);

    // 3: resume over the same PC executes once, second pass traps again
    trap_return = 1;
    step();
    trap_return = 0; d_mode = 0; brk_req = 1; instr_stall = 1;
    repeat (2) step();
    check("t3_skip", {31'd0, trap_req}, 32'd0);
    instr_stall = 0;
    step();
    check("t3_issue", {31'd0, trap_req}, 32'd0);
    step();
    check("t3_again", {31'd0, trap_req}, 32'd1);
    brk_req = 0; trap_ack = 1;
    step();
    trap_ack = 0; d_mode = 1;
    step();
    d_mode = 0;
    step();
    brk_d_mode = 0;
    step();

    // 4: flush in PEND squashes; flush+ack accepts for both modes
    brk_pc = 32'h300; brk_req = 1;
    step();
    brk_req = 0; flush = 1;
    step();
    flush = 0;
    check("t4_flush", {31'd0, trap_req}, 32'd0);
    brk_req = 1;
    step();
    brk_req = 0; flush = 1; trap_ack = 1;
    step();
    flush = 0; trap_ack = 0;
    check("t4_fa_m", {31'd0, trap_req}, 32'd0);
    #1 check("t4_m_idle", {31'd0, suppress_issue}, 32'd0);
    brk_d_mode = 1; brk_req = 1;
    step();
    brk_req = 0; flush = 1; trap_ack = 1;
    step();
    flush = 0; trap_ack = 0;
    #1 check("t4_d_wait", {31'd0, suppress_issue}, 32'd1);
    d_mode = 1;
    step();
    d_mode = 0;
    step();
    step();

    // 5: requests while in D-mode or without a valid instruction are ignored
    brk_req = 1; d_mode = 1;
    repeat (5) step();
    check("t5_dmode", {31'd0, trap_req}, 32'd0);
    d_mode = 0; instr_valid = 0;
    repeat (5) step();
    check("t5_novalid", {31'd0, trap_req}, 32'd0);
    instr_valid = 1; brk_req = 0;
    step();

    // 6: asynchronous reset while PEND
    brk_d_mode = 0; brk_pc = 32'h440; brk_req = 1;
    step();
    check("t6_pend", {31'd0, trap_req}, 32'd1);
    brk_req = 0; instr_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_req", {31'd0, trap_req}, 32'd0);
    check("t6_async_supp", {31'd0, suppress_issue}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6_post", {31'd0, trap_req}, 32'd0);
    step();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      brk_req     = ($urandom_range(0, 1) == 1);
      brk_d_mode  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       brk_pc = 32'h100;
        1:       brk_pc = 32'h2000;
        default: brk_pc = $urandom();
      endcase
      instr_valid = ($urandom_range(0, 3) != 0);
      instr_stall = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      trap_ack    = ($urandom_range(0, 2) == 0);
      trap_return = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) d_mode = ~d_mode;
      step();
    end

    idle_inputs();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
